// File: rtl/dma_arbiter_pkg.sv
// Shared types and defaults for the DMA channel arbiter.
package dma_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        XFER    = 2'd2,
        RELEASE = 2'd3
    } arb_state_e;

    localparam int DATA_W_DEF = 128;

    function automatic int cnt_width(input int timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/dma_arbiter_if.sv
// Requester and DMA-engine signals of the arbiter, one bundle.
interface dma_arbiter_if import dma_arb_pkg::*; #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int DATA_W  = DATA_W_DEF
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_done;
    logic [NUM_REQ-1:0]        req_grant;
    logic [NUM_REQ-1:0]        req_wr_valid;
    logic [NUM_REQ*DATA_W-1:0] req_wr_data;
    logic [NUM_REQ-1:0]        req_wr_ready;
    logic [NUM_REQ-1:0]        req_rd_valid;
    logic [DATA_W-1:0]         req_rd_data;
    logic [NUM_REQ-1:0]        req_rd_ready;
    logic                      dma_req;
    logic                      dma_resp;
    logic                      dma_write_valid;
    logic [DATA_W-1:0]         dma_write_data;
    logic                      dma_write_ready;
    logic                      dma_read_valid;
    logic [DATA_W-1:0]         dma_read_data;
    logic                      dma_read_ready;
    logic [ID_W-1:0]           grant_id;
    logic                      busy;
    logic                      err_timeout;

    modport master (
        input  req_valid, req_done, req_wr_valid, req_wr_data, req_rd_ready,
        input  dma_resp, dma_write_ready, dma_read_valid, dma_read_data,
        output req_grant, req_wr_ready, req_rd_valid, req_rd_data,
        output dma_req, dma_write_valid, dma_write_data, dma_read_ready,
        output grant_id, busy, err_timeout
    );

    modport slave (
        output req_valid, req_done, req_wr_valid, req_wr_data, req_rd_ready,
        output dma_resp, dma_write_ready, dma_read_valid, dma_read_data,
        input  req_grant, req_wr_ready, req_rd_valid, req_rd_data,
        input  dma_req, dma_write_valid, dma_write_data, dma_read_ready,
        input  grant_id, busy, err_timeout
    );

endinterface

// File: rtl/dma_arbiter_rr_pick.sv
// Combinational round-robin selector: first request after 'last', wrapping.
module rr_pick import dma_arb_pkg::*; #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last,
    output logic [ID_W-1:0]    winner,
    output logic               any_valid
);

    logic [ID_W-1:0] cand;

    // Walk from the farthest offset down so the nearest one is written last.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        cand      = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = ID_W'((int'(last) + k) % NUM_REQ);
            if (req[cand]) begin
                winner    = cand;
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_arbiter.sv
// Round-robin owner of the single DMA channel with a response timeout.
module dma_arbiter import dma_arb_pkg::*; #(
    parameter int NUM_REQ      = 4,
    parameter int ID_W         = 2,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int RESP_TIMEOUT = 1024
) (
    input logic           clk,
    input logic           rst,
    dma_arbiter_if.master bus
);

    localparam int CNT_W = cnt_width(RESP_TIMEOUT);

    arb_state_e      state_q, state_d;
    logic [ID_W-1:0] grant_id_q, grant_id_d;
    logic [ID_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            err_timeout_q, err_timeout_d;
    logic [ID_W-1:0] winner;
    logic            any_valid;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req       (bus.req_valid),
        .last      (last_q),
        .winner    (winner),
        .any_valid (any_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            grant_id_q    <= '0;
            last_q        <= ID_W'(NUM_REQ - 1);
            cnt_q         <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_id_q    <= grant_id_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_id_d    = grant_id_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        err_timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (any_valid) begin
                    grant_id_d = winner;
                    state_d    = REQ;
                end
            end
            REQ: begin
                // A response in the final counted cycle still wins.
                if (bus.dma_resp) begin
                    cnt_d   = '0;
                    state_d = XFER;
                end else if (cnt_q == CNT_W'(RESP_TIMEOUT - 1)) begin
                    cnt_d         = '0;
                    err_timeout_d = 1'b1;
                    last_d        = grant_id_q;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            XFER: begin
                if (bus.req_done[grant_id_q]) state_d = RELEASE;
            end
            RELEASE: begin
                last_d  = grant_id_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy            = (state_q != IDLE);
        bus.dma_req         = (state_q == REQ) || (state_q == XFER);
        bus.grant_id        = grant_id_q;
        bus.err_timeout     = err_timeout_q;
        bus.req_rd_data     = bus.dma_read_data;
        bus.req_grant       = '0;
        bus.req_wr_ready    = '0;
        bus.req_rd_valid    = '0;
        bus.dma_write_valid = 1'b0;
        bus.dma_write_data  = '0;
        bus.dma_read_ready  = 1'b0;
        if (state_q == XFER) begin
            bus.req_grant[grant_id_q]    = 1'b1;
            bus.dma_write_valid          = bus.req_wr_valid[grant_id_q];
            bus.dma_write_data           =
                bus.req_wr_data[int'(grant_id_q)*DATA_W +: DATA_W];
            bus.req_wr_ready[grant_id_q] = bus.dma_write_ready;
            bus.req_rd_valid[grant_id_q] = bus.dma_read_valid;
            bus.dma_read_ready           = bus.req_rd_ready[grant_id_q];
        end
    end

endmodule

// File: tb/tb_dma_arbiter.sv
// Directed bench for dma_arbiter: routing table plus multi-cycle sequences.
module tb_dma_arbiter;

    localparam int NR = 4;
    localparam int IDW = 2;
    localparam int DW = 128;
    localparam int TO = 16;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   eng_beats;
    logic [DW-1:0] eng_last;

    dma_arbiter_if #(.NUM_REQ(NR), .ID_W(IDW), .DATA_W(DW)) bif ();

    dma_arbiter #(
        .NUM_REQ      (NR),
        .ID_W         (IDW),
        .DATA_W       (DW),
        .RESP_TIMEOUT (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    typedef struct {
        logic [3:0] wv;
        logic       dwr;
        logic       drv;
        logic [3:0] rr;
        logic       e_dwv;
        logic [3:0] e_wrr;
        logic [3:0] e_rdv;
        logic       e_drr;
    } vec_t;

    vec_t tbl[5];
    int   order[8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial eng_beats = 0;
    initial eng_last = '0;
    always @(posedge clk) begin
        if (bif.dma_write_valid && bif.dma_write_ready) begin
            eng_beats <= eng_beats + 1;
            eng_last  <= bif.dma_write_data;
        end
    end

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output int n);
        n = 0;
        while (!bif.dma_req && n < 20) begin
            tick();
            n++;
        end
        chk("dma_req_wait", 128'(bif.dma_req), 128'(1));
    endtask

    task automatic clear_ins();
        bif.req_valid       = '0;
        bif.req_done        = '0;
        bif.req_wr_valid    = '0;
        bif.req_wr_data     = '0;
        bif.req_rd_ready    = '0;
        bif.dma_resp        = 1'b0;
        bif.dma_write_ready = 1'b0;
        bif.dma_read_valid  = 1'b0;
        bif.dma_read_data   = '0;
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int n;
        int b0;
        total = 0;
        bad   = 0;
        tbl[0] = '{4'b0001, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0100, 4'b0000, 1'b0};
        tbl[1] = '{4'b0101, 1'b1, 1'b1, 4'b0100, 1'b1, 4'b0100, 4'b0100, 1'b1};
        tbl[2] = '{4'b0100, 1'b0, 1'b1, 4'b1011, 1'b1, 4'b0000, 4'b0100, 1'b0};
        tbl[3] = '{4'b1011, 1'b1, 1'b0, 4'b1111, 1'b0, 4'b0100, 4'b0000, 1'b1};
        tbl[4] = '{4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0};
        order = '{0, 1, 2, 3, 0, 1, 2, 3};

        rst = 1'b0;
        clear_ins();
        bif.req_wr_valid    = '1;
        bif.req_rd_ready    = '1;
        bif.dma_write_ready = 1'b1;
        bif.dma_read_valid  = 1'b1;
        #3;
        chk("rst_dma_req", 128'(bif.dma_req), 0);
        chk("rst_grant", 128'(bif.req_grant), 0);
        chk("rst_grant_id", 128'(bif.grant_id), 0);
        chk("rst_busy", 128'(bif.busy), 0);
        chk("rst_err", 128'(bif.err_timeout), 0);
        chk("rst_dwv", 128'(bif.dma_write_valid), 0);
        chk("rst_drr", 128'(bif.dma_read_ready), 0);
        chk("rst_wrr", 128'(bif.req_wr_ready), 0);
        chk("rst_rdv", 128'(bif.req_rd_valid), 0);
        tick();
        tick();
        rst = 1'b1;
        clear_ins();
        tick();

        // single requester, response 3 cycles after dma_req
        bif.req_valid = 4'b0010;
        tick();
        chk("s_dma_req", 128'(bif.dma_req), 1);
        chk("s_grant_req", 128'(bif.req_grant), 0);
        chk("s_grant_id", 128'(bif.grant_id), 1);
        chk("s_busy", 128'(bif.busy), 1);
        repeat (3) tick();
        bif.dma_resp = 1'b1;
        tick();
        bif.dma_resp  = 1'b0;
        bif.req_valid = '0;
        chk("s_grant_xfer", 128'(bif.req_grant), 128'(4'b0010));
        b0 = eng_beats;
        bif.dma_write_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            bif.req_wr_data[1*DW +: DW] = DW'(k);
            bif.req_wr_valid = 4'b0010;
            #1;
            chk("s_wdata", bif.dma_write_data, 128'(k));
            tick();
        end
        bif.req_wr_valid = '0;
        chk("s_beats", 128'(eng_beats - b0), 4);
        bif.req_done = 4'b0010;
        tick();
        bif.req_done = '0;
        chk("s_rel_dma_req", 128'(bif.dma_req), 0);
        chk("s_rel_grant", 128'(bif.req_grant), 0);
        chk("s_rel_busy", 128'(bif.busy), 1);
        tick();
        chk("s_idle_busy", 128'(bif.busy), 0);
        clear_ins();

        // isolation: requester 2 owns, others drive noise
        bif.req_valid = 4'b0100;
        wait_req(n);
        chk("i_grant_id", 128'(bif.grant_id), 2);
        bif.dma_resp = 1'b1;
        tick();
        bif.dma_resp  = 1'b0;
        bif.req_valid = '0;
        chk("i_grant", 128'(bif.req_grant), 128'(4'b0100));
        bif.req_wr_data[0*DW +: DW] = DW'(128'hDEAD);
        bif.req_wr_data[1*DW +: DW] = DW'(128'h1111);
        bif.req_wr_data[2*DW +: DW] = DW'(128'h2222);
        bif.req_wr_data[3*DW +: DW] = DW'(128'h3333);
        bif.dma_read_data = DW'(128'hABCD);
        for (int i = 0; i < 5; i++) begin
            bif.req_wr_valid    = tbl[i].wv;
            bif.dma_write_ready = tbl[i].dwr;
            bif.dma_read_valid  = tbl[i].drv;
            bif.req_rd_ready    = tbl[i].rr;
            #1;
            chk($sformatf("v%0d_dwv", i), 128'(bif.dma_write_valid),
                128'(tbl[i].e_dwv));
            chk($sformatf("v%0d_wrr", i), 128'(bif.req_wr_ready),
                128'(tbl[i].e_wrr));
            chk($sformatf("v%0d_rdv", i), 128'(bif.req_rd_valid),
                128'(tbl[i].e_rdv));
            chk($sformatf("v%0d_drr", i), 128'(bif.dma_read_ready),
                128'(tbl[i].e_drr));
            chk($sformatf("v%0d_wdata", i), bif.dma_write_data,
                128'h2222);
            chk($sformatf("v%0d_rdata", i), bif.req_rd_data, 128'hABCD);
        end
        clear_ins();
        bif.req_done = 4'b0001;
        tick();
        bif.req_done = '0;
        chk("i_foreign_done", 128'(bif.req_grant), 128'(4'b0100));
        bif.req_done = 4'b0100;
        tick();
        bif.req_done = '0;
        chk("i_rel_grant", 128'(bif.req_grant), 0);
        tick();

        // fairness with all requesters held
        pulse_reset();
        bif.req_valid = 4'b1111;
        for (int t = 0; t < 8; t++) begin
            wait_req(n);
            if (t > 0) chk($sformatf("f%0d_gap", t), 128'(n), 2);
            chk($sformatf("f%0d_id", t), 128'(bif.grant_id),
                128'(order[t]));
            bif.dma_resp = 1'b1;
            tick();
            bif.dma_resp = 1'b0;
            chk($sformatf("f%0d_grant", t), 128'(bif.req_grant),
                128'(4'b0001 << order[t]));
            bif.req_done = 4'(4'b0001 << order[t]);
            tick();
            bif.req_done = '0;
        end
        bif.req_valid = '0;
        tick();
        tick();

        // timeout, then the next index wins
        pulse_reset();
        bif.req_valid = 4'b0011;
        wait_req(n);
        chk("t_id", 128'(bif.grant_id), 0);
        repeat (15) tick();
        chk("t_err_early", 128'(bif.err_timeout), 0);
        chk("t_req_held", 128'(bif.dma_req), 1);
        tick();
        chk("t_err", 128'(bif.err_timeout), 1);
        chk("t_req_drop", 128'(bif.dma_req), 0);
        chk("t_busy", 128'(bif.busy), 0);
        tick();
        chk("t_err_pulse", 128'(bif.err_timeout), 0);
        chk("t_next_req", 128'(bif.dma_req), 1);
        chk("t_next_id", 128'(bif.grant_id), 1);

        // response in the timeout cycle; winner drops req_valid in REQ
        bif.req_valid = '0;
        repeat (15) tick();
        chk("r_req_held", 128'(bif.dma_req), 1);
        bif.dma_resp = 1'b1;
        tick();
        bif.dma_resp = 1'b0;
        chk("r_no_err", 128'(bif.err_timeout), 0);
        chk("r_grant", 128'(bif.req_grant), 128'(4'b0010));

        // done together with a write handshake
        b0 = eng_beats;
        bif.req_wr_data[1*DW +: DW] = DW'(128'h55);
        bif.req_wr_valid    = 4'b0010;
        bif.dma_write_ready = 1'b1;
        bif.req_done        = 4'b0010;
        tick();
        clear_ins();
        chk("d_beat", 128'(eng_beats - b0), 1);
        chk("d_data", eng_last, 128'h55);
        chk("d_rel_req", 128'(bif.dma_req), 0);
        chk("d_rel_grant", 128'(bif.req_grant), 0);
        tick();

        // asynchronous reset mid-transfer
        bif.req_valid = 4'b1000;
        wait_req(n);
        chk("a_id", 128'(bif.grant_id), 3);
        bif.dma_resp = 1'b1;
        tick();
        bif.dma_resp     = 1'b0;
        bif.req_valid    = '0;
        bif.req_wr_valid = 4'b1000;
        #1;
        chk("a_dwv_pre", 128'(bif.dma_write_valid), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("a_dma_req", 128'(bif.dma_req), 0);
        chk("a_grant", 128'(bif.req_grant), 0);
        chk("a_dwv", 128'(bif.dma_write_valid), 0);
        chk("a_busy", 128'(bif.busy), 0);
        bif.req_wr_valid = '0;
        tick();
        rst = 1'b1;
        bif.req_valid = 4'b1001;
        wait_req(n);
        chk("a_first_id", 128'(bif.grant_id), 0);
        clear_ins();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dma_arbiter.md
Name: dma_arbiter

Overview:
- Shares the single 128-bit DMA channel (dma_req/dma_resp handshake plus write and read streams) between NUM_REQ requesters.
- Arbitrates round-robin and holds the DMA request until the engine responds.
- Routes both streams between the engine and the granted requester only, until that requester signals done.
- Sits between the NPU load/store units and the DMA controller; adds a response timeout with an error pulse.

Parameters:
- NUM_REQ, 4, number of requesters; 2..8.
- ID_W, 2, width of grant_id; equals clog2(NUM_REQ).
- DATA_W, 128, stream data width.
- RESP_TIMEOUT, 1024, maximum cycles spent in REQ waiting for dma_resp.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- req_valid  in  NUM_REQ  requester i wants a transaction; held high until req_grant[i].
- req_done  in  NUM_REQ  one-cycle pulse from the granted requester ending its transaction.
- req_grant  out  NUM_REQ  one-hot; high while requester i owns the channel.
- req_wr_valid  in  NUM_REQ  per-requester write valid.
- req_wr_data  in  NUM_REQ*DATA_W  packed write data; requester i occupies slice [i*DATA_W +: DATA_W].
- req_wr_ready  out  NUM_REQ  per-requester write ready.
- req_rd_valid  out  NUM_REQ  per-requester read valid.
- req_rd_data  out  DATA_W  read data, broadcast to all requesters.
- req_rd_ready  in  NUM_REQ  per-requester read ready.
- dma_req  out  1  channel request to the DMA engine.
- dma_resp  in  1  engine accepted the request.
- dma_write_valid  out  1  write stream valid toward the engine.
- dma_write_data  out  DATA_W  write stream data.
- dma_write_ready  in  1  engine write ready.
- dma_read_valid  in  1  read stream valid from the engine.
- dma_read_data  in  DATA_W  read stream data.
- dma_read_ready  out  1  read ready toward the engine.
- grant_id  out  ID_W  index of the current owner; valid when busy=1.
- busy  out  1  state is not IDLE.
- err_timeout  out  1  one-cycle pulse when dma_resp does not arrive within RESP_TIMEOUT.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - Outputs: dma_req=0, req_grant=0, grant_id=0, busy=0, err_timeout=0, timeout counter=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has first priority.
  - All routed outputs (dma_write_valid, dma_read_ready, req_wr_ready, req_rd_valid) are 0.
- IDLE:
  - If any req_valid is high, select the first set bit searching from last+1 with wrap-around.
  - Register the winner into grant_id and go to REQ on the next edge.
  - Lowest index wins only relative to the pointer; there is no fixed priority.
- REQ:
  - dma_req=1 (registered, first high in the cycle after the IDLE decision); req_grant remains 0.
  - Timeout counter increments each cycle.
  - dma_resp=1 -> XFER next cycle; counter cleared.
  - Counter reaches RESP_TIMEOUT-1 without dma_resp:
    - err_timeout pulses for one cycle and dma_req drops;
    - last=grant_id, go to IDLE.
  - If dma_resp and timeout occur in the same cycle, dma_resp wins.
  - Deassertion of req_valid by the winner during REQ is ignored.
- XFER:
  - dma_req stays 1; req_grant[grant_id]=1.
  - Streams route combinationally with zero added latency:
    - dma_write_valid=req_wr_valid[id], dma_write_data=slice id, req_wr_ready[id]=dma_write_ready;
    - req_rd_valid[id]=dma_read_valid, dma_read_ready=req_rd_ready[id].
  - Non-granted requesters see req_wr_ready=0 and req_rd_valid=0.
  - req_done[grant_id] -> RELEASE next cycle. A stream beat handshaking in the same cycle as req_done completes normally.
  - req_done from non-granted requesters is ignored.
- RELEASE (1 cycle):
  - dma_req=0, req_grant=0, all routing off.
  - last=grant_id, then go to IDLE.
- Back-to-back transactions have a minimum of 2 idle cycles (RELEASE + IDLE) between the end of one grant and the next dma_req.
- Reset mid-XFER drops the grant and all routing immediately; no beat is completed.

Decomposition:
- Package dma_arb_pkg holds:
  - state encoding IDLE=0, REQ=1, XFER=2, RELEASE=3;
  - DATA_W default;
  - timeout counter width = clog2(RESP_TIMEOUT).
- One sub-module: rr_pick (combinational round-robin selector). Inputs: request vector and last pointer. Outputs: winner index and any_valid.

Test Plan:
- Single requester: req_valid=0b0010, dma_resp 3 cycles after dma_req -> grant_id=1, req_grant=0b0010 in XFER; 4 write beats pass unchanged (data 0x1..0x4); req_done -> dma_req=0 one cycle later.
- Fairness: req_valid=0b1111 held with 8 transactions completed -> grant order 0,1,2,3,0,1,2,3.
- Isolation: requester 2 granted while requester 0 drives req_wr_valid=1 -> dma_write_data equals slice 2 only; req_wr_ready[0]=0; read beat 0xABCD appears only on req_rd_valid[2].
- Timeout: RESP_TIMEOUT=16 with dma_resp never asserted -> err_timeout pulses exactly 16 cycles after dma_req rises; dma_req drops; next winner is the next index.
- Simultaneous events: dma_resp in the timeout cycle -> XFER with no err_timeout. req_done together with a write handshake -> beat counted at the engine, then RELEASE.
- Async reset (rst=0) mid-XFER -> dma_req, req_grant and dma_write_valid go to 0 without waiting for a clock edge; after release, requester 0 wins first.
